div_seq32: RTL and testbench

DIV_SEQ32 -- requirements
Module: div_seq32

---
 rtl/div_seq32_pkg.sv | 19 +
 rtl/div_seq32_if.sv | 24 ++
 rtl/div_seq32_bla_subtractor32.sv | 38 +++
 rtl/div_seq32.sv | 105 ++++++++++
 tb/tb_div_seq32.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/div_seq32_pkg.sv
// Shared definitions for the sequential 32-bit unsigned divider.
package div_pkg;

  localparam int WIDTH      = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // True on the count value of the final restoring-division step.
  function automatic logic last_iter(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(ITER_COUNT - 1);
  endfunction

endpackage

// File: rtl/div_seq32_if.sv
// Request/result bundle of the divider: operands in, status and results out.
interface div_seq32_if;
  import div_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_seq32_bla_subtractor32.sv
// 32-bit borrow-look-ahead subtractor: diff = a - b, bout = 1 when a < b.
// Borrows are resolved per 4-bit group with group generate/propagate terms,
// and the group borrows ripple between groups.
module bla_subtractor32 (
  output logic        bout,
  output logic [31:0] diff,
  input  logic [31:0] a,
  input  logic [31:0] b
);

  logic [31:0] gen;
  logic [31:0] prop;
  logic        grp_g;
  logic        grp_p;
  logic        cin;

  // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
  always_comb begin
    gen   = ~a & b;
    prop  = ~(a ^ b);
    diff  = '0;
    grp_g = 1'b0;
    grp_p = 1'b1;
    cin   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int j = 0; j < 4; j++) begin
        diff[4*k+j] = a[4*k+j] ^ b[4*k+j] ^ (grp_g | (grp_p & cin));
        grp_g = gen[4*k+j] | (prop[4*k+j] & grp_g);
        grp_p = prop[4*k+j] & grp_p;
      end
      cin = grp_g | (grp_p & cin);
    end
    bout = cin;
  end

endmodule

// File: rtl/div_seq32.sv
// Sequential restoring divider, one quotient bit per clock.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on the accepting edge
//   CALC  | 32 shift/subtract steps, busy high
//   DONE  | one-cycle done pulse with registered results
module div_seq32
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_seq32_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;

  logic [WIDTH-1:0] trial_a;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_bout;
  logic             accept;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  bla_subtractor32 u_sub (
    .bout (trial_bout),
    .diff (trial_diff),
    .a    (trial_a),
    .b    (d_reg)
  );

  // One restoring step. A set R[31] means the 33-bit shifted partial
  // remainder already exceeds any 32-bit divisor, so the subtraction is
  // taken even though the 32-bit subtractor reports a borrow.
  always_comb begin
    trial_a = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    accept  = ~trial_bout | r_reg[WIDTH-1];
    r_next  = accept ? trial_diff : trial_a;
    q_next  = {q_reg[WIDTH-2:0], accept};
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      d_reg           <= '0;
      q_reg           <= '0;
      r_reg           <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            d_reg <= bus.divisor;
            q_reg <= bus.dividend;
            r_reg <= '0;
            count <= '0;
            if (bus.divisor == '0) begin
              state           <= DONE;
              bus.done        <= 1'b1;
              bus.div_by_zero <= 1'b1;
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend;
            end else begin
              state    <= CALC;
              bus.busy <= 1'b1;
            end
          end
        end
        CALC: begin
          r_reg <= r_next;
          q_reg <= q_next;
          count <= count + CNT_W'(1);
          if (last_iter(count)) begin
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.div_by_zero <= 1'b0;
            bus.quotient    <= q_next;
            bus.remainder   <= r_next;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq32.sv
// Directed and random checks of div_seq32 using an expected-result queue.
module tb_div_seq32;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_seq32_if bus ();

  div_seq32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Pushes the expectation and pulses start for one edge. Returns at the
  // falling edge of the first cycle after the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    sb.push_back(model(a, b));
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done starting at cycle index cyc0 after the
  // accepting edge, then compares latency, busy cycles, results and pulse width.
  task automatic collect(input string tag, input int cyc0, input int exp_lat, input int exp_busy);
    int   busy_n = 0;
    int   lat    = -1;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = cyc0 + i;
        break;
      end
      if (bus.busy === 1'b1) busy_n++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_quotient"}, bus.quotient, e.q);
      check({tag, "_remainder"}, bus.remainder, e.r);
      check({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'(e.dz));
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
      check({tag, "_quotient_hold"}, bus.quotient, e.q);
    end
  endtask

  initial begin
    exp_t        e;
    logic [31:0] ra;
    logic [31:0] rb;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_quotient", bus.quotient, 32'd0);
    check("reset_remainder", bus.remainder, 32'd0);
    check("reset_dz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;

    launch(32'd100, 32'd7);
    collect("d100_7", 1, 33, 32);

    launch(32'hFFFF_FFFF, 32'd1);
    collect("ffff_1", 1, 33, 32);

    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect("ffff_ffff", 1, 33, 32);

    launch(32'h8000_0000, 32'hFFFF_FFFF);
    collect("r31_rule", 1, 33, 32);

    launch(32'd7, 32'd100);
    collect("d7_100", 1, 33, 32);

    launch(32'd5, 32'd0);
    collect("div0", 1, 1, 0);

    // Start pulsed mid-calculation with other operands left on the inputs.
    launch(32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    collect("ignored_start", 6, 33, 27);

    // Reset in the middle of CALC, then start on the first edge after release.
    launch(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    void'(sb.pop_back());
    bus.start = 1'b0;
    rst       = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_quotient", bus.quotient, 32'd0);
    check("abort_remainder", bus.remainder, 32'd0);
    check("abort_dz", 32'(bus.div_by_zero), 32'd0);
    sb.push_back(model(32'd9, 32'd3));
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    collect("after_abort", 1, 33, 32);

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      case (n % 4)
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 255));
        2:       rb = ra >> $urandom_range(0, 31);
        default: rb = (n == 7) ? 32'd0 : 32'($urandom_range(1, 65535));
      endcase
      launch(ra, rb);
      collect("random", 1, (rb == 0) ? 1 : 33, (rb == 0) ? 0 : 32);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
